spi_cmd_link: RTL and testbench

SPI_CMD_LINK -- requirements
Module: spi_cmd_link

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 56 +++++
 rtl/spi_cmd_link.sv | 189 ++++++++++++++++++
 tb/tb_spi_cmd_link.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state type, synchronizer depth and TX load delay for the SPI command link
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  // Flops in each input synchronizer chain.
  localparam int SYNC_DEPTH = 3;

  // Clock cycles between a ready strobe and the TX register load.
  localparam int TX_LOAD_DELAY = 2;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - single-bit synchronizer with rise/fall pulse outputs and optional glitch filter
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0,
  parameter bit   FILTER  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  cur_s;
  logic                  prev_s;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_DEPTH{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], d_i};
    end
  end

  // Edges are judged between the last two stages of the chain.
  assign cur_s  = sync_q[SYNC_DEPTH-2];
  assign prev_s = sync_q[SYNC_DEPTH-1];

  generate
    if (FILTER) begin : g_filt
      logic level_q;
      logic stable;

      assign stable = (cur_s == prev_s);

      // Accept a new level only once two consecutive samples agree.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          level_q <= RST_VAL;
        end else if (stable) begin
          level_q <= cur_s;
        end
      end

      assign rise_o = stable &  cur_s & ~level_q;
      assign fall_o = stable & ~cur_s &  level_q;
    end else begin : g_raw
      assign rise_o =  cur_s & ~prev_s;
      assign fall_o = ~cur_s &  prev_s;
    end
  endgenerate

endmodule

// File: rtl/spi_cmd_link.sv
// rtl/spi_cmd_link.sv - SPI mode-0 slave that frames command/parameter bytes; SPI_SCK_GLITCH_FILTER_EN enables the SCK glitch filter
module spi_cmd_link
  import spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sck,
  input  logic        spi_ssel,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [7:0]  spi_data_in,
  output logic        cmd_ready,
  output logic        param_ready,
  output logic [7:0]  cmd_data,
  output logic [7:0]  param_data,
  output logic [31:0] spi_byte_cnt,
  output logic [2:0]  spi_bit_cnt,
  output logic        frame_active
);

`ifdef SPI_SCK_GLITCH_FILTER_EN
  localparam bit SckFilter = 1'b1;
`else
  localparam bit SckFilter = 1'b0;
`endif

  logic sck_rise;
  logic sck_fall;
  logic ssel_rise;
  logic ssel_fall;
  logic mosi_s;

  logic [SYNC_DEPTH-1:0]    mosi_q;
  spi_state_e               state_q,       state_d;
  logic [6:0]               rx_q,          rx_d;
  logic [7:0]               byte_q,        byte_d;
  logic [7:0]               tx_q,          tx_d;
  logic [2:0]               bit_cnt_q,     bit_cnt_d;
  logic [31:0]              byte_cnt_q,    byte_cnt_d;
  logic                     done_q,        done_d;
  logic                     first_q,       first_d;
  logic                     cmd_ready_q,   cmd_ready_d;
  logic                     param_ready_q, param_ready_d;
  logic [7:0]               cmd_data_q,    cmd_data_d;
  logic [7:0]               param_data_q,  param_data_d;
  logic [TX_LOAD_DELAY-1:0] ld_pipe_q,     ld_pipe_d;

  spi_sync_edge #(
    .RST_VAL (1'b0),
    .FILTER  (SckFilter)
  ) u_sck_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_sck),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync_edge #(
    .RST_VAL (1'b1),
    .FILTER  (1'b0)
  ) u_ssel_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_ssel),
    .rise_o (ssel_rise),
    .fall_o (ssel_fall)
  );

  // MOSI synchronizer; the last stage is sampled, which is stable well inside a mode-0 bit time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_q <= '0;
    end else begin
      mosi_q <= {mosi_q[SYNC_DEPTH-2:0], spi_mosi};
    end
  end

  assign mosi_s = mosi_q[SYNC_DEPTH-1];

  // Frame FSM and datapath next-state: shift bits, count bytes, stage strobes and TX loads.
  always_comb begin
    state_d       = state_q;
    rx_d          = rx_q;
    byte_d        = byte_q;
    tx_d          = tx_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    done_d        = 1'b0;
    first_d       = first_q;
    cmd_ready_d   = 1'b0;
    param_ready_d = 1'b0;
    cmd_data_d    = cmd_data_q;
    param_data_d  = param_data_q;
    ld_pipe_d     = {ld_pipe_q[TX_LOAD_DELAY-2:0], done_q};

    // A completed byte is reported one cycle later as command or parameter.
    if (done_q) begin
      if (first_q) begin
        cmd_ready_d = 1'b1;
        cmd_data_d  = byte_q;
      end else begin
        param_ready_d = 1'b1;
        param_data_d  = byte_q;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (ssel_fall) begin
          state_d    = ACTIVE;
          byte_cnt_d = 32'd0;
          bit_cnt_d  = 3'd0;
          tx_d       = 8'h00;
        end
      end
      ACTIVE: begin
        if (ssel_rise) begin
          // Deselect wins over any coincident SCK edge and drops a partial byte.
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
        end else begin
          if (sck_rise) begin
            rx_d      = {rx_q[5:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_d     = {rx_q, mosi_s};
              done_d     = 1'b1;
              first_d    = (byte_cnt_q == 32'd0);
              byte_cnt_d = sat_inc32(byte_cnt_q);
            end
          end
          // The fall that closes a byte does not shift, so the next byte's MSB
          // loaded between bytes is still on MISO at the following rise.
          if (sck_fall && (bit_cnt_q != 3'd0)) begin
            tx_d = {tx_q[6:0], 1'b0};
          end
          if (ld_pipe_q[TX_LOAD_DELAY-1]) begin
            tx_d = spi_data_in;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rx_q          <= '0;
      byte_q        <= '0;
      tx_q          <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      done_q        <= 1'b0;
      first_q       <= 1'b0;
      cmd_ready_q   <= 1'b0;
      param_ready_q <= 1'b0;
      cmd_data_q    <= '0;
      param_data_q  <= '0;
      ld_pipe_q     <= '0;
    end else begin
      state_q       <= state_d;
      rx_q          <= rx_d;
      byte_q        <= byte_d;
      tx_q          <= tx_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      done_q        <= done_d;
      first_q       <= first_d;
      cmd_ready_q   <= cmd_ready_d;
      param_ready_q <= param_ready_d;
      cmd_data_q    <= cmd_data_d;
      param_data_q  <= param_data_d;
      ld_pipe_q     <= ld_pipe_d;
    end
  end

  assign spi_miso     = (state_q == ACTIVE) & tx_q[7];
  assign cmd_ready    = cmd_ready_q;
  assign param_ready  = param_ready_q;
  assign cmd_data     = cmd_data_q;
  assign param_data   = param_data_q;
  assign spi_byte_cnt = byte_cnt_q;
  assign spi_bit_cnt  = bit_cnt_q;
  assign frame_active = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_cmd_link.sv
// tb/tb_spi_cmd_link.sv - randomized self-checking bench for spi_cmd_link against a byte-level frame model
module tb_spi_cmd_link;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_ssel = 1'b1;
  logic        spi_mosi = 1'b0;
  logic [7:0]  spi_data_in = 8'h00;
  logic        spi_miso;
  logic        cmd_ready;
  logic        param_ready;
  logic [7:0]  cmd_data;
  logic [7:0]  param_data;
  logic [31:0] spi_byte_cnt;
  logic [2:0]  spi_bit_cnt;
  logic        frame_active;

  always #5 clk = ~clk;

  spi_cmd_link dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_sck      (spi_sck),
    .spi_ssel     (spi_ssel),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_data_in  (spi_data_in),
    .cmd_ready    (cmd_ready),
    .param_ready  (param_ready),
    .cmd_data     (cmd_data),
    .param_data   (param_data),
    .spi_byte_cnt (spi_byte_cnt),
    .spi_bit_cnt  (spi_bit_cnt),
    .frame_active (frame_active)
  );

`ifdef SPI_SCK_GLITCH_FILTER_EN
  localparam int GlitchBits = 0;
`else
  localparam int GlitchBits = 1;
`endif

  int checks = 0;
  int errors = 0;

  // Expected strobes: kind (1 = command), byte value, byte count during the strobe.
  bit         exp_kind_q[$];
  logic [7:0] exp_data_q[$];
  int         exp_cnt_q[$];
  logic [7:0] exp_last_cmd = 8'h00;

  logic [7:0] param_log[$];
  int         pcnt_log[$];
  int         n_cmd = 0;
  int         n_param = 0;

  logic [7:0] fb[8];
  logic [7:0] rb[8];
  logic [7:0] miso_got[8];

  bit         cmp_k;
  logic [7:0] cmp_d;
  int         cmp_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every strobe against the frame model's expectation queue.
  always @(negedge clk) begin
    if (rst_n && (cmd_ready || param_ready)) begin
      check("strobe_exclusive", 32'(cmd_ready & param_ready), 32'd0);
      if (exp_kind_q.size() == 0) begin
        check("unexpected_strobe", 32'(cmd_ready), 32'(param_ready));
        check("unexpected_strobe_any", 32'd1, 32'd0 + 32'(exp_kind_q.size()));
      end else begin
        cmp_k = exp_kind_q.pop_front();
        cmp_d = exp_data_q.pop_front();
        cmp_c = exp_cnt_q.pop_front();
        check("strobe_kind", 32'(cmd_ready), 32'(cmp_k));
        check("strobe_data", 32'(cmd_ready ? cmd_data : param_data), 32'(cmp_d));
        check("strobe_byte_cnt", spi_byte_cnt, 32'(cmp_c));
        if (param_ready) check("cmd_data_held", 32'(cmd_data), 32'(exp_last_cmd));
      end
      if (cmd_ready) begin
        n_cmd++;
      end else begin
        n_param++;
        param_log.push_back(param_data);
        pcnt_log.push_back(int'(spi_byte_cnt));
      end
    end
  end

  // Act as the MCU: send nfull whole bytes plus 'extra' bits, sampling MISO on each rise.
  task automatic spi_frame(input int nfull, input int extra, input int half, input bit close);
    logic [7:0] got;
    logic [7:0] want;
    int nb;
    spi_ssel = 1'b0;
    for (int b = 0; b < nfull + ((extra > 0) ? 1 : 0); b++) begin
      nb   = (b < nfull) ? 8 : extra;
      want = (b == 0) ? 8'h00 : rb[b-1];
      got  = 8'h00;
      for (int i = 0; i < nb; i++) begin
        spi_mosi = fb[b][7-i];
        repeat (half) @(negedge clk);
        spi_sck = 1'b1;
        got[7-i] = spi_miso;
        if (i == 0) spi_data_in = rb[b];
        if (i == 7) begin
          exp_kind_q.push_back(b == 0);
          exp_data_q.push_back(fb[b]);
          exp_cnt_q.push_back(b + 1);
          if (b == 0) exp_last_cmd = fb[0];
        end
        repeat (6) @(negedge clk);
        check("bit_cnt", 32'(spi_bit_cnt), 32'((i + 1) % 8));
        check("byte_cnt", spi_byte_cnt, 32'(b + ((i == 7) ? 1 : 0)));
        check("frame_active", 32'(frame_active), 32'd1);
        repeat (half - 6) @(negedge clk);
        spi_sck = 1'b0;
      end
      if (nb == 8) begin
        miso_got[b] = got;
        check("miso_byte", 32'(got), 32'(want));
      end
    end
    if (close) begin
      repeat (half) @(negedge clk);
      spi_ssel = 1'b1;
      repeat (12) @(negedge clk);
      check("bit_cnt_idle", 32'(spi_bit_cnt), 32'd0);
      check("frame_active_idle", 32'(frame_active), 32'd0);
      check("byte_cnt_hold", spi_byte_cnt, 32'(nfull));
      for (int t = 0; t < 40 && exp_kind_q.size() != 0; t++) @(negedge clk);
      check("strobes_drained", 32'(exp_kind_q.size()), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, 32'({cmd_ready, param_ready, cmd_data, param_data,
                               spi_bit_cnt, frame_active, spi_miso}), 32'd0);
    check({name, "_byte_cnt"}, spi_byte_cnt, 32'd0);
  endtask

  int nc;
  int np;
  int nfull;
  int extra;

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_after_reset", 32'(frame_active), 32'd0);

    // Single command byte.
    fb[0] = 8'hF0; rb[0] = 8'h00;
    nc = n_cmd; np = n_param;
    spi_frame(1, 0, 10, 1'b1);
    check("f0_cmd_count", 32'(n_cmd - nc), 32'd1);
    check("f0_param_count", 32'(n_param - np), 32'd0);
    check("f0_cmd_data", 32'(cmd_data), 32'hF0);
    check("f0_byte_cnt", spi_byte_cnt, 32'd1);

    // Command plus three parameters.
    fb[0] = 8'h10; fb[1] = 8'h12; fb[2] = 8'h34; fb[3] = 8'h56;
    for (int i = 0; i < 4; i++) rb[i] = 8'h00;
    param_log.delete(); pcnt_log.delete();
    spi_frame(4, 0, 8, 1'b1);
    check("p3_count", 32'(param_log.size()), 32'd3);
    if (param_log.size() == 3) begin
      check("p3_data0", 32'(param_log[0]), 32'h12);
      check("p3_data1", 32'(param_log[1]), 32'h34);
      check("p3_data2", 32'(param_log[2]), 32'h56);
      check("p3_cnt0", 32'(pcnt_log[0]), 32'd2);
      check("p3_cnt1", 32'(pcnt_log[1]), 32'd3);
      check("p3_cnt2", 32'(pcnt_log[2]), 32'd4);
    end
    check("p3_cmd_data", 32'(cmd_data), 32'h10);

    // Response byte returned on MISO during the second byte.
    fb[0] = 8'h5A; fb[1] = 8'h00; rb[0] = 8'hA5; rb[1] = 8'h00;
    spi_frame(2, 0, 10, 1'b1);
    check("a5_miso_byte0", 32'(miso_got[0]), 32'h00);
    check("a5_miso_byte1", 32'(miso_got[1]), 32'hA5);

    // Deselect after five bits of the second byte.
    fb[0] = 8'hC3; fb[1] = 8'hFF; rb[0] = 8'h00; rb[1] = 8'h00;
    nc = n_cmd; np = n_param;
    spi_frame(1, 5, 9, 1'b1);
    check("abort_cmd_count", 32'(n_cmd - nc), 32'd1);
    check("abort_param_count", 32'(n_param - np), 32'd0);
    check("abort_bit_cnt", 32'(spi_bit_cnt), 32'd0);
    fb[0] = 8'h77; fb[1] = 8'hE1; rb[0] = 8'h3E; rb[1] = 8'h00;
    param_log.delete();
    spi_frame(2, 0, 9, 1'b1);
    check("after_abort_cmd", 32'(cmd_data), 32'h77);
    check("after_abort_param", 32'(param_data), 32'hE1);

    // Reset mid-byte with the frame still open.
    fb[0] = 8'h3C; fb[1] = 8'h99; rb[0] = 8'h81; rb[1] = 8'h00;
    spi_frame(1, 3, 9, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    spi_ssel = 1'b1;
    spi_sck  = 1'b0;
    exp_kind_q.delete(); exp_data_q.delete(); exp_cnt_q.delete();
    exp_last_cmd = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_all_zero("post_reset_idle");
    fb[0] = 8'hB4; fb[1] = 8'h2D; rb[0] = 8'h69; rb[1] = 8'h00;
    spi_frame(2, 0, 10, 1'b1);
    check("post_reset_cmd", 32'(cmd_data), 32'hB4);

    // SCK glitch handling: a 1-clk pulse counts only without the filter; a 2-clk pulse always counts.
    spi_ssel = 1'b0;
    repeat (10) @(negedge clk);
    spi_sck = 1'b1;
    @(negedge clk);
    spi_sck = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_1clk", 32'(spi_bit_cnt), 32'(GlitchBits));
    spi_sck = 1'b1;
    repeat (2) @(negedge clk);
    spi_sck = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_2clk", 32'(spi_bit_cnt), 32'(GlitchBits + 1));
    spi_ssel = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_close", 32'(spi_bit_cnt), 32'd0);

    // Randomized frames, some ending mid-byte.
    for (int f = 0; f < 16; f++) begin
      nfull = int'($urandom_range(1, 5));
      extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      for (int b = 0; b < 8; b++) begin
        fb[b] = 8'($urandom);
        rb[b] = 8'($urandom);
      end
      spi_frame(nfull, extra, int'($urandom_range(8, 12)), 1'b1);
      repeat ($urandom_range(3, 20)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
